// File: rtl/pwm_ramp_sequencer.sv
// Duty ramp controller for the 8-bit PWM core.
// Tracks the core's period so duty/width changes land on period boundaries.
module pwm_ramp_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] target_duty,
  input  logic [3:0] step,
  input  logic [7:0] hold,
  input  logic [2:0] bits_cfg,
  output logic [7:0] duty_out,
  output logic [2:0] bits_out,
  output logic       period_tick,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RAMP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] duty_d;
  logic [2:0] bits_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] tgt_q, tgt_d;
  logic [3:0] step_q, step_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] bcfg_q, bcfg_d;
  logic       done_d;

  logic       up;
  logic [8:0] diff;
  logic [7:0] stepped;
  logic [7:0] next_duty;

  assign period_tick = (pcnt_q == (8'd1 << bits_out));
  assign busy        = (state_q != IDLE);

  // Saturate to target when the remaining distance fits in one step
  always_comb begin
    up        = (tgt_q > duty_out);
    diff      = up ? ({1'b0, tgt_q} - {1'b0, duty_out})
                   : ({1'b0, duty_out} - {1'b0, tgt_q});
    stepped   = up ? (duty_out + {4'd0, step_q})
                   : (duty_out - {4'd0, step_q});
    next_duty = (diff <= {5'd0, step_q}) ? tgt_q : stepped;
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = period_tick ? 8'd0 : pcnt_q + 8'd1;
    duty_d  = duty_out;
    bits_d  = bits_out;
    hcnt_d  = hcnt_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    hold_d  = hold_q;
    bcfg_d  = bcfg_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          tgt_d   = target_duty;
          step_d  = (step == 4'd0) ? 4'd1 : step;
          hold_d  = (hold == 8'd0) ? 8'd1 : hold;
          bcfg_d  = bits_cfg;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_tick) begin
          bits_d = bcfg_q;
          hcnt_d = hold_q;
          if (duty_out == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (period_tick) begin
          if (hcnt_q <= 8'd1) begin
            duty_d = next_duty;
            hcnt_d = hold_q;
            if (next_duty == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pcnt_q   <= 8'd0;
      duty_out <= 8'd0;
      bits_out <= 3'd0;
      hcnt_q   <= 8'd0;
      tgt_q    <= 8'd0;
      step_q   <= 4'd0;
      hold_q   <= 8'd0;
      bcfg_q   <= 3'd0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      duty_out <= duty_d;
      bits_out <= bits_d;
      hcnt_q   <= hcnt_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      bcfg_q   <= bcfg_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer.
// Vector table of ramps plus directed reset/abort sequences.
module tb_pwm_ramp_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] target_duty = 8'd0;
  logic [3:0] step = 4'd0;
  logic [7:0] hold = 8'd0;
  logic [2:0] bits_cfg = 3'd0;
  logic [7:0] duty_out;
  logic [2:0] bits_out;
  logic       period_tick;
  logic       busy;
  logic       done;

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]      bits;
    logic [7:0]      tgt;
    logic [3:0]      stp;
    logic [7:0]      hld;
    int              n;
    logic [3:0][7:0] seq;
  } vec_t;

  vec_t vecs [9];

  pwm_ramp_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .target_duty(target_duty),
    .step(step),
    .hold(hold),
    .bits_cfg(bits_cfg),
    .duty_out(duty_out),
    .bits_out(bits_out),
    .period_tick(period_tick),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the ALIGN tick edge
  task automatic wait_align(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (period_tick) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    chk({name, " align tick seen"}, int'(seen), 1);
    cyc();
  endtask

  task automatic wait_step(input string name, input logic [7:0] prev,
                           output int cnt, output int ft);
    cnt = 0;
    ft  = -1;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      cnt++;
      if (period_tick && ft < 0) ft = cnt;
      if (duty_out != prev) break;
    end
    if (duty_out == prev) chk({name, " step timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] prev;
    int h, per, cnt, ft;
    string nm;
    nm   = $sformatf("vec%0d", idx);
    prev = duty_out;
    bits_cfg    = v.bits;
    target_duty = v.tgt;
    step        = v.stp;
    hold        = v.hld;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk({nm, " busy after start"}, int'(busy), 1);
    wait_align(nm);
    chk({nm, " bits_out"}, int'(bits_out), int'(v.bits));
    h   = (v.hld == 8'd0) ? 1 : int'(v.hld);
    per = (1 << v.bits) + 1;
    if (v.n == 0) begin
      chk({nm, " done on align"}, int'(done), 1);
      chk({nm, " busy on align"}, int'(busy), 0);
      chk({nm, " duty kept"}, int'(duty_out), int'(prev));
    end
    for (int k = 0; k < v.n; k++) begin
      wait_step(nm, prev, cnt, ft);
      chk($sformatf("%s step%0d interval", nm, k), cnt, h * per);
      if (k == 0) chk({nm, " first tick"}, ft, 1 << v.bits);
      chk($sformatf("%s step%0d duty", nm, k), int'(duty_out),
          int'(v.seq[k]));
      chk($sformatf("%s step%0d done", nm, k), int'(done),
          int'(k == v.n - 1));
      chk($sformatf("%s step%0d busy", nm, k), int'(busy),
          int'(k != v.n - 1));
      prev = duty_out;
    end
    cyc();
    chk({nm, " done one cycle"}, int'(done), 0);
  endtask

  task automatic chk_idle_ticks(input string name);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk($sformatf("%s tick%0d", name, i), int'(period_tick), i % 2);
    end
  endtask

  initial begin
    int cnt, ft, ndone;
    bit dchg;
    vecs[0] = '{3'd3, 8'd8,  4'd3,  8'd2, 3, {8'd0, 8'd8,  8'd6,  8'd3}};
    vecs[1] = '{3'd2, 8'd0,  4'd5,  8'd1, 2, {8'd0, 8'd0,  8'd0,  8'd3}};
    vecs[2] = '{3'd1, 8'd2,  4'd0,  8'd0, 2, {8'd0, 8'd0,  8'd2,  8'd1}};
    vecs[3] = '{3'd5, 8'd2,  4'd7,  8'd3, 0, {8'd0, 8'd0,  8'd0,  8'd0}};
    vecs[4] = '{3'd4, 8'd0,  4'd15, 8'd3, 1, {8'd0, 8'd0,  8'd0,  8'd0}};
    vecs[5] = '{3'd0, 8'd40, 4'd15, 8'd1, 3, {8'd0, 8'd40, 8'd30, 8'd15}};
    vecs[6] = '{3'd2, 8'd37, 4'd4,  8'd1, 1, {8'd0, 8'd0,  8'd0,  8'd37}};
    vecs[7] = '{3'd1, 8'd4,  4'd4,  8'd1, 1, {8'd0, 8'd0,  8'd0,  8'd4}};
    vecs[8] = '{3'd3, 8'd50, 4'd5,  8'd1, 0, {8'd0, 8'd0,  8'd0,  8'd0}};

    // Power-up reset and idle period ticks
    repeat (3) cyc();
    chk("rst duty", int'(duty_out), 0);
    chk("rst bits", int'(bits_out), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst tick", int'(period_tick), 0);
    rst = 1'b0;
    chk_idle_ticks("idle");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset mid-run, released with start low
    #2 rst = 1'b1;
    #1;
    chk("midrst duty", int'(duty_out), 0);
    chk("midrst bits", int'(bits_out), 0);
    cyc();
    rst = 1'b0;
    chk_idle_ticks("post-rst");
    chk("post-rst busy", int'(busy), 0);

    // Abort during ramp-up; start while busy must be ignored
    bits_cfg = 3'd3;
    target_duty = 8'd8;
    step = 4'd3;
    hold = 8'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_align("abort");
    target_duty = 8'd100;
    step = 4'd15;
    hold = 8'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_step("abort", 8'd0, cnt, ft);
    chk("abort step0 duty", int'(duty_out), 3);
    wait_step("abort", 8'd3, cnt, ft);
    chk("abort step1 duty", int'(duty_out), 6);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort duty", int'(duty_out), 6);
    chk("abort done", int'(done), 0);
    ndone = 0;
    dchg = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (done) ndone++;
      if (duty_out != 8'd6) dchg = 1'b1;
    end
    chk("abort no done", ndone, 0);
    chk("abort duty held", int'(dchg), 0);
    chk("abort bits held", int'(bits_out), 3);

    // Async reset mid-ramp, then a fresh ramp
    bits_cfg = vecs[8].bits;
    target_duty = vecs[8].tgt;
    step = vecs[8].stp;
    hold = vecs[8].hld;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_align("arst");
    wait_step("arst", 8'd6, cnt, ft);
    chk("arst pre duty", int'(duty_out), 11);
    #2 rst = 1'b1;
    #1;
    chk("arst duty", int'(duty_out), 0);
    chk("arst bits", int'(bits_out), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    cyc();
    rst = 1'b0;
    run_vec(vecs[7], 7);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
